// File: rtl/bisr_proxy_pkg.sv
// Shared types and helpers for the BISR weight-proxy flow.
//   proxy_state_e : sequencer states of the proxy scanner
//   WEIGHT_W      : width of a signed two's-complement weight
//   abs32()       : unsigned magnitude of a 32-bit signed weight; also used
//                   by the remap logic
package bisr_proxy_pkg;

  localparam int WEIGHT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } proxy_state_e;

  // 0x80000000 maps to 2^31. The result is unsigned, so the most negative
  // weight becomes the largest magnitude rather than saturating or wrapping
  // to a negative number.
  function automatic logic [WEIGHT_W-1:0] abs32(input logic [WEIGHT_W-1:0] w);
    return w[WEIGHT_W-1] ? (~w + WEIGHT_W'(1)) : w;
  endfunction

endpackage

// File: rtl/weight_proxy_scanner_abs_cmp.sv
// 32-bit absolute-value comparator used as the single compare instance of
// the proxy scanner.
// Ports:
//   i_a      : signed two's-complement operand (incoming weight)
//   i_b_abs  : unsigned magnitude operand (running best magnitude)
//   o_a_abs  : unsigned |i_a|
//   o_lt     : |i_a| < i_b_abs, strictly, unsigned
module weight_proxy_scanner_abs_cmp
  import bisr_proxy_pkg::*;
(
  input  logic [WEIGHT_W-1:0] i_a,
  input  logic [WEIGHT_W-1:0] i_b_abs,
  output logic [WEIGHT_W-1:0] o_a_abs,
  output logic                o_lt
);

  logic [WEIGHT_W-1:0] w_a_abs;

  assign w_a_abs = abs32(i_a);
  assign o_a_abs = w_a_abs;
  assign o_lt    = (w_a_abs < i_b_abs);

endmodule

// File: rtl/weight_proxy_scanner.sv
// Weight-proxy scanner: streams one column's weights and selects the healthy
// PE whose weight has the smallest magnitude. That PE becomes the proxy for a
// faulty PE.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : begin a scan (honoured in IDLE or DONE only)
//   fault_mask_i  : bit k = 1 excludes PE k; captured on start
//   w_valid_i / w_ready_o / w_data_i : weight stream, beat k = PE k
//   busy_o        : high while scanning
//   done_o        : one-cycle pulse when the results below update
//   found_o       : at least one unmasked candidate existed
//   min_idx_o     : index of the selected proxy
//   min_abs_o     : unsigned magnitude of the selected proxy's weight
module weight_proxy_scanner
  import bisr_proxy_pkg::*;
#(
  parameter  int NUM_WEIGHTS = 16,
  localparam int IDX_W       = $clog2(NUM_WEIGHTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [NUM_WEIGHTS-1:0] fault_mask_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [WEIGHT_W-1:0]    w_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   found_o,
  output logic [IDX_W-1:0]       min_idx_o,
  output logic [WEIGHT_W-1:0]    min_abs_o
);

  proxy_state_e            r_state;
  proxy_state_e            w_state_next;

  logic [NUM_WEIGHTS-1:0]  r_mask;
  logic [IDX_W-1:0]        r_count;
  logic                    r_best_valid;
  logic [IDX_W-1:0]        r_best_idx;
  logic [WEIGHT_W-1:0]     r_best_abs;

  logic                    w_start;
  logic                    w_beat;
  logic                    w_last;
  logic                    w_cmp_lt;
  logic [WEIGHT_W-1:0]     w_cmp_abs;
  logic                    w_take;
  logic                    w_fin_valid;
  logic [IDX_W-1:0]        w_fin_idx;
  logic [WEIGHT_W-1:0]     w_fin_abs;

  // start_i is only honoured between scans; during SCAN it is ignored.
  assign w_start = start_i && ((r_state == IDLE) || (r_state == DONE));
  assign w_beat  = w_valid_i && (r_state == SCAN);
  assign w_last  = (r_count == IDX_W'(NUM_WEIGHTS - 1));

  weight_proxy_scanner_abs_cmp u_abs_cmp (
    .i_a     (w_data_i),
    .i_b_abs (r_best_abs),
    .o_a_abs (w_cmp_abs),
    .o_lt    (w_cmp_lt)
  );

  // Strict less-than means an equal magnitude never displaces the earlier
  // beat, so ties resolve to the lower index.
  assign w_take = w_beat && !r_mask[r_count] && (!r_best_valid || w_cmp_lt);

  // Result of the scan including the beat on this edge; published on the
  // final handshake so it is visible together with done_o.
  assign w_fin_valid = r_best_valid || w_take;
  assign w_fin_idx   = w_take ? r_count   : r_best_idx;
  assign w_fin_abs   = w_take ? w_cmp_abs : r_best_abs;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order of the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_ready_o    = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) w_state_next = SCAN;
      end
      SCAN: begin
        w_ready_o = 1'b1;
        busy_o    = 1'b1;
        if (w_beat && w_last) w_state_next = DONE;
      end
      DONE: begin
        done_o       = 1'b1;
        w_state_next = start_i ? SCAN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask       <= '0;
      r_count      <= '0;
      r_best_valid <= 1'b0;
      r_best_idx   <= '0;
      r_best_abs   <= '0;
      found_o      <= 1'b0;
      min_idx_o    <= '0;
      min_abs_o    <= '0;
    end else if (w_start) begin
      r_mask       <= fault_mask_i;
      r_count      <= '0;
      r_best_valid <= 1'b0;
    end else if (w_beat) begin
      r_count <= r_count + IDX_W'(1);
      if (w_take) begin
        r_best_valid <= 1'b1;
        r_best_idx   <= r_count;
        r_best_abs   <= w_cmp_abs;
      end
      // With no unmasked candidate the published index and magnitude are
      // forced to zero instead of exposing stale best registers.
      if (w_last) begin
        found_o   <= w_fin_valid;
        min_idx_o <= w_fin_valid ? w_fin_idx : '0;
        min_abs_o <= w_fin_valid ? w_fin_abs : '0;
      end
    end
  end

endmodule
